// File: rtl/coin_credit_frontend_pkg.sv
// Shared vending datapath types: coin/item/credit widths,
// front-end FSM states and default coin values.
package vend_pkg;

    typedef logic [1:0] coin_t;
    typedef logic [1:0] item_t;
    typedef logic [3:0] credit_t;

    localparam int CREDIT_MAX = 15;

    localparam credit_t COIN0_DEF = 4'd1;
    localparam credit_t COIN1_DEF = 4'd2;
    localparam credit_t COIN2_DEF = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        REQUEST,
        CHECK
    } fe_state_t;

endpackage

// File: rtl/coin_credit_frontend_if.sv
// Front-end <-> vending core bus: request values out,
// registered dispense/balance results back.
interface vend_core_if;

    vend_pkg::credit_t deposited_amount;
    vend_pkg::item_t   item_code;
    logic              dispense;
    vend_pkg::credit_t balance;

    modport master (
        output deposited_amount,
        output item_code,
        input  dispense,
        input  balance
    );

    modport slave (
        input  deposited_amount,
        input  item_code,
        output dispense,
        output balance
    );

endinterface

// File: rtl/coin_credit_frontend_coin_decoder.sv
// Maps a coin denomination to its credit value;
// type 2'b11 is flagged invalid.
module coin_decoder
    import vend_pkg::*;
#(
    parameter credit_t COIN0_VAL = COIN0_DEF,
    parameter credit_t COIN1_VAL = COIN1_DEF,
    parameter credit_t COIN2_VAL = COIN2_DEF
) (
    input  coin_t   coin_type,
    output credit_t value,
    output logic    invalid
);

    always_comb begin
        value   = '0;
        invalid = 1'b0;
        unique case (coin_type)
            2'b00:   value = COIN0_VAL;
            2'b01:   value = COIN1_VAL;
            2'b10:   value = COIN2_VAL;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/coin_credit_frontend.sv
// Coin credit front end: accumulates credit, issues one-cycle
// requests to the vending core and reports the outcome.
module coin_credit_frontend
    import vend_pkg::*;
#(
    parameter credit_t COIN0_VAL = COIN0_DEF,
    parameter credit_t COIN1_VAL = COIN1_DEF,
    parameter credit_t COIN2_VAL = COIN2_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        coin_valid,
    input  coin_t       coin_type,
    input  logic        select_valid,
    input  item_t       select_code,
    input  logic        cancel,
    vend_core_if.master core,
    output logic        coin_reject,
    output logic        vend_done,
    output logic        insufficient,
    output logic        refund_valid,
    output credit_t     refund_amount,
    output credit_t     credit,
    output logic        busy
);

    fe_state_t state_q, state_d;
    credit_t   credit_q, credit_d;
    item_t     item_q, item_d;
    credit_t   dep_q, dep_d;
    credit_t   ramt_q, ramt_d;
    logic      rej_q, rej_d;
    logic      vend_q, vend_d;
    logic      insuf_q, insuf_d;
    logic      rv_q, rv_d;
    logic      busy_q, busy_d;

    credit_t   coin_val;
    logic      coin_inv;
    logic [4:0] sum;
    logic      coin_ok;

    coin_decoder #(
        .COIN0_VAL (COIN0_VAL),
        .COIN1_VAL (COIN1_VAL),
        .COIN2_VAL (COIN2_VAL)
    ) u_dec (
        .coin_type (coin_type),
        .value     (coin_val),
        .invalid   (coin_inv)
    );

    // 5-bit sum so an overflowing coin is detected, never wrapped
    assign sum     = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok = !coin_inv && (sum <= 5'(CREDIT_MAX));

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        item_d   = item_q;
        ramt_d   = '0;
        rej_d    = 1'b0;
        vend_d   = 1'b0;
        insuf_d  = 1'b0;
        rv_d     = 1'b0;
        unique case (state_q)
            IDLE, CREDIT: begin
                if (cancel && state_q == CREDIT) begin
                    rv_d     = 1'b1;
                    ramt_d   = credit_q;
                    credit_d = '0;
                    state_d  = IDLE;
                    rej_d    = coin_valid;
                end else if (select_valid && state_q == CREDIT) begin
                    item_d  = select_code;
                    state_d = REQUEST;
                    rej_d   = coin_valid;
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = sum[3:0];
                        state_d  = (sum[3:0] != '0) ? CREDIT : state_q;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            REQUEST: begin
                state_d = CHECK;
                rej_d   = coin_valid;
            end
            CHECK: begin
                rej_d = coin_valid;
                if (core.dispense) begin
                    vend_d   = 1'b1;
                    rv_d     = (core.balance != '0);
                    ramt_d   = core.balance;
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    insuf_d = 1'b1;
                    state_d = CREDIT;
                end
            end
            default: state_d = IDLE;
        endcase
        dep_d  = (state_d == REQUEST) ? credit_d : '0;
        busy_d = (state_d == REQUEST) || (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            item_q   <= '0;
            dep_q    <= '0;
            ramt_q   <= '0;
            rej_q    <= 1'b0;
            vend_q   <= 1'b0;
            insuf_q  <= 1'b0;
            rv_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            dep_q    <= dep_d;
            ramt_q   <= ramt_d;
            rej_q    <= rej_d;
            vend_q   <= vend_d;
            insuf_q  <= insuf_d;
            rv_q     <= rv_d;
            busy_q   <= busy_d;
        end
    end

    assign core.deposited_amount = dep_q;
    assign core.item_code        = item_q;
    assign coin_reject           = rej_q;
    assign vend_done             = vend_q;
    assign insufficient          = insuf_q;
    assign refund_valid          = rv_q;
    assign refund_amount         = ramt_q;
    assign credit                = credit_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_coin_credit_frontend.sv
// Scoreboard bench for coin_credit_frontend with a small
// registered vending-core model (prices 5/7/10/12).
module tb_coin_credit_frontend;
    import vend_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        coin_valid = 1'b0;
    logic [1:0]  coin_type = 2'b00;
    logic        select_valid = 1'b0;
    logic [1:0]  select_code = 2'b00;
    logic        cancel = 1'b0;
    logic        coin_reject, vend_done, insufficient;
    logic        refund_valid, busy;
    logic [3:0]  refund_amount, credit;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rej;
        logic       vend;
        logic       insuf;
        logic       rv;
        logic [3:0] amt;
    } exp_t;

    exp_t sb[$];

    vend_core_if cif ();

    coin_credit_frontend dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .select_valid  (select_valid),
        .select_code   (select_code),
        .cancel        (cancel),
        .core          (cif.master),
        .coin_reject   (coin_reject),
        .vend_done     (vend_done),
        .insufficient  (insufficient),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .credit        (credit),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] price_of(logic [1:0] c);
        case (c)
            2'b00:   return 4'd5;
            2'b01:   return 4'd7;
            2'b10:   return 4'd10;
            default: return 4'd12;
        endcase
    endfunction

    // vending core model: registers result from the presented request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cif.dispense <= 1'b0;
            cif.balance  <= 4'd0;
        end else if (cif.deposited_amount != 4'd0 &&
                     cif.deposited_amount >= price_of(cif.item_code)) begin
            cif.dispense <= 1'b1;
            cif.balance  <= cif.deposited_amount - price_of(cif.item_code);
        end else begin
            cif.dispense <= 1'b0;
            cif.balance  <= 4'd0;
        end
    end

    // monitor: pop one expectation per cycle with any pulse present
    always @(negedge clk) begin
        exp_t e;
        if (coin_reject || vend_done || insufficient || refund_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: rej=%0b vend=%0b insuf=%0b rv=%0b amt=%0d, none expected",
                         coin_reject, vend_done, insufficient, refund_valid, refund_amount);
            end else begin
                e = sb.pop_front();
                if (coin_reject !== e.rej || vend_done !== e.vend ||
                    insufficient !== e.insuf || refund_valid !== e.rv ||
                    refund_amount !== e.amt) begin
                    fails++;
                    $display("FAIL pulse: got rej=%0b vend=%0b insuf=%0b rv=%0b amt=%0d, expected rej=%0b vend=%0b insuf=%0b rv=%0b amt=%0d",
                             coin_reject, vend_done, insufficient, refund_valid, refund_amount,
                             e.rej, e.vend, e.insuf, e.rv, e.amt);
                end
            end
        end
        if (!refund_valid && refund_amount != 4'd0) begin
            tests++;
            fails++;
            $display("FAIL refund_amount_idle: got %0d expected 0", refund_amount);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic rej, input logic vend, input logic insuf,
                        input logic rv, input logic [3:0] amt);
        exp_t e;
        e.rej = rej; e.vend = vend; e.insuf = insuf; e.rv = rv; e.amt = amt;
        sb.push_back(e);
    endtask

    task automatic coin(input logic [1:0] t);
        @(posedge clk); #1;
        coin_valid = 1'b1;
        coin_type  = t;
        @(posedge clk); #1;
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [1:0] code, input int exp_dep);
        @(posedge clk); #1;
        select_valid = 1'b1;
        select_code  = code;
        @(posedge clk); #1;
        select_valid = 1'b0;
        check("request_deposit", cif.deposited_amount, exp_dep);
        check("request_item", cif.item_code, code);
        check("request_busy", busy, 1);
        @(posedge clk); #1;
        check("check_busy", busy, 1);
        check("check_deposit", cif.deposited_amount, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic do_cancel();
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_credit", credit, 0);
        check("reset_busy", busy, 0);
        check("reset_deposit", cif.deposited_amount, 0);
        check("reset_item", cif.item_code, 0);
        check("reset_pulses", {coin_reject, vend_done, insufficient, refund_valid}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // cancel and select with zero credit are ignored
        @(posedge clk); #1;
        cancel = 1'b1; select_valid = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0; select_valid = 1'b0;
        check("idle_ignore_busy", busy, 0);

        // exact payment
        coin(2'b10); coin(2'b01);
        check("credit_7", credit, 7);
        push(0, 1, 0, 0, 0);
        sel(2'b01, 7);
        check("vend_exact_credit", credit, 0);

        // vend with change
        coin(2'b10); coin(2'b10);
        push(0, 1, 0, 1, 5);
        sel(2'b00, 10);
        check("vend_change_credit", credit, 0);

        // insufficient then cancel
        coin(2'b10); coin(2'b01);
        push(0, 0, 1, 0, 0);
        sel(2'b10, 7);
        check("insuf_credit_kept", credit, 7);
        check("insuf_not_busy", busy, 0);
        push(0, 0, 0, 1, 7);
        do_cancel();
        check("cancel_credit", credit, 0);
        @(posedge clk); #1;
        check("cancel_idle_busy", busy, 0);

        // saturation and invalid coin
        coin(2'b10); coin(2'b10); coin(2'b10);
        check("credit_15", credit, 15);
        push(1, 0, 0, 0, 0);
        coin(2'b00);
        check("overflow_credit", credit, 15);
        push(1, 0, 0, 0, 0);
        coin(2'b11);
        check("invalid_credit", credit, 15);
        push(0, 0, 0, 1, 15);
        do_cancel();
        check("cancel15_credit", credit, 0);

        // select beats coin; coin during CHECK rejected
        coin(2'b10);
        check("credit_5", credit, 5);
        push(1, 0, 0, 0, 0);
        push(1, 1, 0, 0, 0);
        @(posedge clk); #1;
        select_valid = 1'b1; select_code = 2'b00;
        coin_valid = 1'b1; coin_type = 2'b01;
        @(posedge clk); #1;
        select_valid = 1'b0; coin_valid = 1'b0;
        check("prio_deposit", cif.deposited_amount, 5);
        @(posedge clk); #1;
        coin_valid = 1'b1; coin_type = 2'b00;
        @(posedge clk); #1;
        coin_valid = 1'b0;
        check("check_coin_reject", coin_reject, 1);
        check("prio_vend", vend_done, 1);
        @(posedge clk); #1;
        check("prio_credit", credit, 0);

        // reset during CHECK
        coin(2'b10); coin(2'b10);
        check("credit_10", credit, 10);
        @(posedge clk); #1;
        select_valid = 1'b1; select_code = 2'b10;
        @(posedge clk); #1;
        select_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {coin_reject, vend_done, insufficient, refund_valid}, 0);
        check("rst_refund_amt", refund_amount, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_credit", credit, 0);

        // recovers normally after reset
        coin(2'b01);
        check("post_rst_coin", credit, 2);
        push(0, 0, 0, 1, 2);
        do_cancel();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coin_credit_frontend.md
# coin_credit_frontend

- Upstream stage of the vending datapath.
- Accepts coin events, accumulates a saturating 4-bit credit and latches an item selection.
- Presents `deposited_amount` and `item_code` to the vending core for exactly one evaluation cycle, then consumes the core's registered `dispense` and `balance` results.
- Reports vend completion, insufficient credit, change and refunds.

## Interface
Parameters:
- `COIN0_VAL`, default 1: credit value of `coin_type` 2'b00.
- `COIN1_VAL`, default 2: credit value of `coin_type` 2'b01.
- `COIN2_VAL`, default 5: credit value of `coin_type` 2'b10. `coin_type` 2'b11 is an invalid coin.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `coin_valid` in 1: one-cycle coin event.
- `coin_type` in 2: denomination, qualified by `coin_valid`.
- `select_valid` in 1: one-cycle selection request.
- `select_code` in 2: item code, qualified by `select_valid`.
- `cancel` in 1: one-cycle cancel/refund request.
- `dispense` in 1: registered result from the vending core.
- `balance` in 4: registered remaining amount from the vending core.
- `deposited_amount` out 4: credit presented to the core.
- `item_code` out 2: latched selection presented to the core.
- `coin_reject` out 1: one-cycle pulse, coin not credited.
- `vend_done` out 1: one-cycle pulse, item dispensed.
- `insufficient` out 1: one-cycle pulse, credit below price.
- `refund_valid` out 1: one-cycle pulse, change or refund being returned.
- `refund_amount` out 4: amount returned, qualified by `refund_valid`.
- `credit` out 4: current accumulated credit, for display.
- `busy` out 1: high in REQUEST and CHECK.

## Operation
- FSM states: IDLE (credit 0), CREDIT (credit > 0), REQUEST, CHECK.
- Coin acceptance: in IDLE or CREDIT, a coin with `credit + value <= 15` adds `value` to credit.
  - Invalid type, overflow past 15, or a coin arriving in REQUEST or CHECK causes `coin_reject` and no credit change.
  - Credit arithmetic is 5-bit internally; credit never wraps.
- Event priority in a single cycle: cancel > select > coin. A coin dropped because of a higher-priority event raises `coin_reject`.
- `select_valid` in IDLE (credit 0) is ignored.
- `select_valid` in CREDIT latches `select_code` into `item_code` and moves to REQUEST.
- REQUEST lasts 1 cycle and drives `deposited_amount = credit`. Next state is CHECK.
- `deposited_amount` is 0 in every state other than REQUEST, which keeps the core idle (all core prices are ≥ 5).
- CHECK lasts 1 cycle and samples `dispense` and `balance`, which the core registered from the REQUEST values.
  - If `dispense` = 1: pulse `vend_done`. If `balance` ≠ 0, pulse `refund_valid` with `refund_amount = balance`. Clear credit and go to IDLE.
  - If `dispense` = 0: pulse `insufficient`. Credit is retained; go to CREDIT.
- `cancel` in CREDIT: pulse `refund_valid` with `refund_amount = credit`, clear credit, go to IDLE.
- `cancel` in IDLE is ignored.
- `cancel` and `select_valid` in REQUEST or CHECK are ignored; the transaction always completes.
- `item_code` holds its last value outside REQUEST.

## Timing
- Reset values: all outputs 0, `credit` 0, `item_code` 2'b00, state IDLE. Reset takes effect immediately and asynchronously.
- Reset asserted mid-transaction (REQUEST or CHECK) discards credit with no refund pulse. The core's own reset is expected to coincide.
- All outputs are registered.
- Coin to `credit` update latency: 1 cycle.
- Select to REQUEST: 1 cycle. REQUEST to CHECK: 1 cycle.
- Result pulses (`vend_done`, `insufficient`, `refund_valid`) are registered out of CHECK, i.e. 3 cycles after the `select_valid` edge.
- Cancel to `refund_valid`: 1 cycle.
- All pulse outputs are exactly one cycle wide. `refund_amount` is 0 whenever `refund_valid` = 0.

## Structure
- Shared package `vend_pkg` holds:
  - `coin_t` (2-bit), `item_t` (2-bit) and `credit_t` (4-bit).
  - `CREDIT_MAX = 15`.
  - The FSM state enum `fe_state_t` {IDLE, CREDIT, REQUEST, CHECK}.
  - Default coin values.
- Natural sub-module: `coin_decoder`, a combinational map from `coin_type` to value plus invalid flag. The FSM and credit register stay in the top level.

## Test plan
- Coins 5, 2, then select 01 (price 7): core returns dispense = 1, balance 0. Expect `vend_done`, no `refund_valid`, `credit` = 0.
- Coins 5, 5, then select 00 (price 5): expect `vend_done`, plus `refund_valid` with `refund_amount` = 5.
- Coins 5, 2, then select 10 (price 10): expect `insufficient`, `credit` stays 7. Then `cancel`: expect `refund_valid` with `refund_amount` = 7, state IDLE.
- Coins 5, 5, 5 give credit 15. A further coin 1 gives `coin_reject` with credit still 15. `coin_type` 2'b11 also gives `coin_reject`.
- Same cycle `select_valid` (code 00) plus coin 2 with credit 5: select wins, `coin_reject` pulses, `deposited_amount` = 5 in REQUEST. A coin arriving during CHECK is rejected.
- `reset_n` low during CHECK with credit 10: all outputs go to 0 immediately, no refund pulse, state IDLE after release.
